// File: rtl/vector_result_serializer.sv
// rtl/vector_result_serializer.sv - drains a captured result vector as a serial element stream
//
// Purpose:
//   Snapshots an N-lane result vector and its length on start, then presents
//   the elements in index order 0..eff_len-1 over a valid/ready handshake.
//   The final element is flagged with out_last, and done pulses for one cycle
//   after the stream completes (or right after a zero-length capture).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   capture vec_in/vec_len and begin streaming (IDLE only)
//   vec_in     in   BITS x N result vector
//   vec_len    in   8-bit number of valid elements (clamped to N)
//   busy       out  high while streaming
//   out_data   out  current element
//   out_index  out  lane index of out_data
//   out_valid  out  out_data/out_index/out_last are valid
//   out_ready  in   downstream accepts the current element
//   out_last   out  current element is the final one
//   done       out  one-cycle pulse after stream completion

module vector_result_serializer #(
  parameter int BITS = 8,
  parameter int N    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] vec_in [N-1:0],
  input  logic [7:0]      vec_len,
  output logic            busy,
  output logic [BITS-1:0] out_data,
  output logic [7:0]      out_index,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            done
);

  // Lane-select width: just wide enough to address N buffer entries.
  localparam int         IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] N_LEN = 8'(N);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [BITS-1:0] buffer [N-1:0];
  logic [7:0]      eff_len;
  logic [7:0]      idx;

  logic [7:0]      cap_len;
  logic            capture;
  logic            beat;
  logic            last_elem;

  // Lengths above N clamp to N rather than wrapping.
  assign cap_len   = (vec_len > N_LEN) ? N_LEN : vec_len;
  assign capture   = (state == IDLE) && start;
  assign beat      = (state == STREAM) && out_ready;
  // eff_len is never zero while in STREAM, so the subtraction cannot underflow there.
  assign last_elem = (idx == (eff_len - 8'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && (cap_len != 8'd0)) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (beat && last_elem) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Index, captured length and done pulse.
  // On the last beat idx is left alone; outputs are gated by state, and the
  // next capture reloads it, so idx never steps past eff_len-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 8'd0;
      eff_len <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        idx     <= 8'd0;
        eff_len <= cap_len;
        done    <= (cap_len == 8'd0);
      end else if (beat) begin
        if (last_elem) begin
          done <= 1'b1;
        end else begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  // Snapshot buffer; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      buffer <= vec_in;
    end
  end

  // Output decode: everything is zero outside STREAM.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = 8'd0;
    out_last  = 1'b0;
    if (state == STREAM) begin
      busy      = 1'b1;
      out_valid = 1'b1;
      out_data  = buffer[idx[IW-1:0]];
      out_index = idx;
      out_last  = last_elem;
    end
  end

endmodule

// File: tb/tb_vector_result_serializer.sv
// tb/tb_vector_result_serializer.sv - self-checking bench for vector_result_serializer

module tb_vector_result_serializer;

  localparam int BITS = 8;
  localparam int N    = 64;

  logic            clk;
  logic            rst;
  logic            start;
  logic [BITS-1:0] vec_in [N-1:0];
  logic [7:0]      vec_len;
  logic            busy;
  logic [BITS-1:0] out_data;
  logic [7:0]      out_index;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            done;

  int total;
  int bad;

  vector_result_serializer #(.BITS(BITS), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_in    (vec_in),
    .vec_len   (vec_len),
    .busy      (busy),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(output logic [BITS-1:0] v [N-1:0]);
    for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
  endtask

  task automatic test_reset();
    logic [BITS-1:0] tmp [N-1:0];
    fill_random(tmp);
    vec_in    = tmp;
    vec_len   = 8'd5;
    start     = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h want=0", out_data); end
    total++; if (out_index !== 8'h00) begin bad++; $display("FAIL reset_index got=%0d want=0", out_index); end
    rst   = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) vec_in[i] = 8'(i + 16);
    vec_len   = 8'd4;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid k=%0d got=%b want=1", k, out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy k=%0d got=%b want=1", k, busy); end
      total++; if (out_data !== 8'(k + 16)) begin bad++; $display("FAIL basic_data k=%0d got=%0h want=%0h", k, out_data, 8'(k + 16)); end
      total++; if (out_index !== 8'(k)) begin bad++; $display("FAIL basic_index k=%0d got=%0d want=%0d", k, out_index, k); end
      total++; if (out_last !== (k == 3)) begin bad++; $display("FAIL basic_last k=%0d got=%b want=%b", k, out_last, (k == 3)); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_early_done k=%0d got=%b want=0", k, done); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_backpressure();
    logic [BITS-1:0] ref_v [N-1:0];
    logic            pat [6];
    int              beats;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    fill_random(ref_v);
    vec_in  = ref_v;
    vec_len = 8'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=1", c, out_valid); end
      total++; if (out_data !== ref_v[beats]) begin bad++; $display("FAIL bp_data c=%0d got=%0h want=%0h", c, out_data, ref_v[beats]); end
      total++; if (out_index !== 8'(beats)) begin bad++; $display("FAIL bp_index c=%0d got=%0d want=%0d", c, out_index, beats); end
      total++; if (out_last !== (beats == 2)) begin bad++; $display("FAIL bp_last c=%0d got=%b want=%b", c, out_last, (beats == 2)); end
      out_ready = pat[c];
      tick();
      if (pat[c]) beats++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b want=0", out_valid); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_len();
    vec_len = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid2 got=%b want=0", out_valid); end
  endtask

  task automatic test_clamp();
    logic [BITS-1:0] ref_v [N-1:0];
    int              errs;
    fill_random(ref_v);
    vec_in    = ref_v;
    vec_len   = 8'd200;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    errs  = 0;
    for (int k = 0; k < N; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clamp_valid k=%0d got=%b want=1", k, out_valid); end
      total++; if (out_index !== 8'(k)) begin bad++; $display("FAIL clamp_index k=%0d got=%0d want=%0d", k, out_index, k); end
      total++; if (out_data !== ref_v[k]) begin bad++; $display("FAIL clamp_data k=%0d got=%0h want=%0h", k, out_data, ref_v[k]); end
      total++; if (out_last !== (k == N - 1)) begin bad++; $display("FAIL clamp_last k=%0d got=%b want=%b", k, out_last, (k == N - 1)); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL clamp_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clamp_extra_beat got=%b want=0", out_valid); end
    tick();
  endtask

  task automatic test_snapshot();
    logic [BITS-1:0] ref_v [N-1:0];
    fill_random(ref_v);
    for (int i = 0; i < N; i++) if (ref_v[i] == 8'hFF) ref_v[i] = 8'h5A;
    vec_in    = ref_v;
    vec_len   = 8'd5;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) vec_in[i] = 8'hFF;
    vec_len = 8'd2;
    for (int k = 0; k < 5; k++) begin
      total++; if (out_data !== ref_v[k]) begin bad++; $display("FAIL snap_data k=%0d got=%0h want=%0h", k, out_data, ref_v[k]); end
      total++; if (out_index !== 8'(k)) begin bad++; $display("FAIL snap_index k=%0d got=%0d want=%0d", k, out_index, k); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL snap_valid k=%0d got=%b want=1", k, out_valid); end
      // Hold start high from mid-stream through the last beat; none of these may restart.
      if (k >= 2) start = 1'b1;
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL snap_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL snap_restart got=%b want=0", out_valid); end
    // start is still high in the done cycle: this one is accepted.
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL snap2_valid k=%0d got=%b want=1", k, out_valid); end
      total++; if (out_data !== 8'hFF) begin bad++; $display("FAIL snap2_data k=%0d got=%0h want=ff", k, out_data); end
      total++; if (out_index !== 8'(k)) begin bad++; $display("FAIL snap2_index k=%0d got=%0d want=%0d", k, out_index, k); end
      total++; if (out_last !== (k == 1)) begin bad++; $display("FAIL snap2_last k=%0d got=%b want=%b", k, out_last, (k == 1)); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL snap2_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [BITS-1:0] ref_v [N-1:0];
    fill_random(ref_v);
    vec_in    = ref_v;
    vec_len   = 8'd5;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++; if (out_index !== 8'd2) begin bad++; $display("FAIL rmid_pre_index got=%0d want=2", out_index); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%0h want=0", out_data); end
    total++; if (out_index !== 8'h00) begin bad++; $display("FAIL rmid_index got=%0d want=0", out_index); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rmid_last got=%b want=0", out_last); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_late_done got=%b want=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid2 got=%b want=0", out_valid); end
    vec_len = 8'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid2_valid k=%0d got=%b want=1", k, out_valid); end
      total++; if (out_index !== 8'(k)) begin bad++; $display("FAIL rmid2_index k=%0d got=%0d want=%0d", k, out_index, k); end
      total++; if (out_data !== ref_v[k]) begin bad++; $display("FAIL rmid2_data k=%0d got=%0h want=%0h", k, out_data, ref_v[k]); end
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid2_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_single();
    logic [BITS-1:0] ref_v [N-1:0];
    fill_random(ref_v);
    vec_in    = ref_v;
    vec_len   = 8'd1;
    out_ready = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid c=%0d got=%b want=1", c, out_valid); end
      total++; if (out_last !== 1'b1) begin bad++; $display("FAIL single_last c=%0d got=%b want=1", c, out_last); end
      total++; if (out_index !== 8'd0) begin bad++; $display("FAIL single_index c=%0d got=%0d want=0", c, out_index); end
      total++; if (out_data !== ref_v[0]) begin bad++; $display("FAIL single_data c=%0d got=%0h want=%0h", c, out_data, ref_v[0]); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL single_early_done c=%0d got=%b want=0", c, done); end
      out_ready = (c == 3);
      tick();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b want=0", out_valid); end
    tick();
  endtask

  // Randomized traffic against a queue model: on capture the queue is loaded
  // with the first min(vec_len, N) elements; each accepted beat pops the head.
  task automatic test_random();
    logic [BITS-1:0] q_data [$];
    int              q_base;
    logic            exp_done;
    logic            nd;
    logic            exp_valid;
    int              len;
    int              r;
    q_data.delete();
    q_base   = 0;
    exp_done = 1'b0;
    start    = 1'b0;
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_valid = (q_data.size() != 0);
      total++; if (out_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_valid); end
      total++; if (busy !== exp_valid) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, exp_valid); end
      total++; if (done !== exp_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", cyc, done, exp_done); end
      if (exp_valid) begin
        total++; if (out_data !== q_data[0]) begin bad++; $display("FAIL rnd_data cyc=%0d got=%0h want=%0h", cyc, out_data, q_data[0]); end
        total++; if (out_index !== 8'(q_base)) begin bad++; $display("FAIL rnd_index cyc=%0d got=%0d want=%0d", cyc, out_index, q_base); end
        total++; if (out_last !== (q_data.size() == 1)) begin bad++; $display("FAIL rnd_last cyc=%0d got=%b want=%b", cyc, out_last, (q_data.size() == 1)); end
      end else begin
        total++; if ({out_data, out_index, out_last} !== 17'd0) begin bad++; $display("FAIL rnd_idle_outs cyc=%0d got=%0h/%0d/%b want=0", cyc, out_data, out_index, out_last); end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) vec_in[i] = BITS'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      vec_len = 8'd0;
      else if (r == 1) vec_len = 8'($urandom_range(65, 255));
      else if (r == 2) vec_len = 8'($urandom_range(1, 64));
      else             vec_len = 8'($urandom_range(1, 6));
      nd = 1'b0;
      if (q_data.size() != 0) begin
        if (out_ready) begin
          void'(q_data.pop_front());
          q_base++;
          if (q_data.size() == 0) nd = 1'b1;
        end
      end else if (start) begin
        len = (int'(vec_len) > N) ? N : int'(vec_len);
        for (int i = 0; i < len; i++) q_data.push_back(vec_in[i]);
        q_base = 0;
        if (len == 0) nd = 1'b1;
      end
      exp_done = nd;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    vec_len   = 8'd0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) vec_in[i] = '0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_clamp();
    test_snapshot();
    test_reset_mid();
    test_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_result_serializer.md
Name: vector_result_serializer

Overview:
- Drains a registered result vector from the vector element ALU (S[N-1:0] plus an 8-bit length) as a serial element stream.
- Uses a valid/ready handshake toward the host-interface side (UART/HAL bridge).
- Snapshots the vector on start, so the ALU is free to compute the next result while the stream is draining.
- Emits elements in index order 0..len-1, flags the final element and pulses done when the stream completes.

Parameters:
- BITS, 8, element width in bits.
- N, 64, number of vector lanes. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to capture vec_in/vec_len and begin streaming; acted on only in IDLE.
- vec_in  input  BITS x N (unpacked [N-1:0])  result vector from the ALU.
- vec_len  input  8  number of valid elements in vec_in.
- busy  output  1  high while in the STREAM state.
- out_data  output  BITS  current element.
- out_index  output  8  lane index of out_data.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current element.
- out_last  output  1  current element is the final one.
- done  output  1  one-cycle pulse after the stream completes.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, out_valid=0, out_last=0, out_data=0, out_index=0, done=0. The snapshot buffer need not be cleared.
- Reset takes priority over every other input. Reset mid-stream aborts the stream with no done pulse.
- Effective length: eff_len = min(vec_len, N), computed at the capture edge. Lengths above N are clamped, never wrapped.
- State machine: IDLE -> STREAM -> IDLE.
- IDLE:
  - start=1 at edge t: buffer <= vec_in, eff_len captured, idx <= 0.
  - If eff_len>0: go to STREAM. At cycle t+1, out_valid=1, out_index=0, out_data=vec_in[0] as sampled at t.
  - If eff_len==0: stay in IDLE, done=1 for the cycle t+1, and no beats are emitted.
- STREAM:
  - out_valid=1 continuously.
  - out_data=buffer[idx], out_index=idx.
  - out_last=(idx==eff_len-1).
- Beat = out_valid & out_ready at a rising edge.
  - On a non-last beat: idx <= idx+1, and the next element is presented the following cycle. Throughput is 1 element/cycle with out_ready held high.
  - On the last beat: go to IDLE; out_valid=0 and done=1 for exactly the next cycle.
- Backpressure: while out_ready=0, out_data, out_index and out_last hold stable and out_valid stays 1. valid is never withdrawn before the handshake.
- start while in STREAM is ignored. A start in the same cycle as the last beat is also ignored; a new start is accepted from the done cycle onward.
- A start during the done cycle is legal. It captures new data, and its first element appears the next cycle.
- Changes on vec_in/vec_len after capture have no effect on the stream in progress.
- Outside STREAM: out_data=0, out_index=0, out_last=0.
- idx never exceeds eff_len-1 and never wraps.
- Timing: start to first element is 1 cycle. Total stream time with continuous ready is 1+eff_len cycles, with done at cycle t+1+eff_len.

Test Plan:
- Basic stream, N=64: vec_in[i]=i+0x10, vec_len=4, start pulse, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles starting at t+1; out_last only on 0x13; done=1 at t+5; busy=0 after.
- Backpressure: vec_len=3, out_ready toggled 1,0,0,1,0,1 -> exactly 3 beats, in order. Data, index and last stay stable during the ready=0 cycles, and valid never drops mid-stream.
- Zero and clamped length:
  - vec_len=0 -> no out_valid, done=1 at t+1.
  - vec_len=200 -> exactly 64 beats (indices 0..63), with out_last on index 63.
- Snapshot and start-ignore: after start, overwrite vec_in with 0xFF and pulse start again mid-stream -> original values still stream, and no restart occurs. A start in the done cycle begins a new stream of 0xFF data.
- Reset mid-stream: assert rst after beat 2 of 5 -> the next cycle shows all outputs 0, state IDLE, no done pulse. A following start with vec_len=2 streams indices 0,1 normally.
- Single element: vec_len=1, out_ready=0 for 3 cycles then 1 -> out_last=1 and out_index=0 held for 4 cycles, with done one cycle after the beat.
